// File: rtl/vm_pkg.sv
// Shared types for the parametrised vending machine: FSM states, coin codes
// and the coin-to-units conversion.
package vm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    REFUND  = 2'd2
  } vm_state_e;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;
  localparam logic [1:0] COIN_BAD  = 2'd3;

  // Value of a coin code in 0.5-yuan units; the invalid code is worth nothing.
  function automatic logic [1:0] coin_units(input logic [1:0] code);
    logic [1:0] units;
    case (code)
      COIN_NONE: units = 2'd0;
      COIN_HALF: units = 2'd1;
      COIN_ONE:  units = 2'd2;
      COIN_BAD:  units = 2'd0;
      default:   units = 2'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/param_vending_machine_if.sv
// Front-panel / mechanism bundle of the vending machine: coin and button
// inputs plus the vend, change and status outputs.
interface vm_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          i_money;
  logic                i_cancel;
  logic                i_refill;
  logic                o_cola;
  logic                o_change;
  logic                o_busy;
  logic                o_sold_out;
  logic [CREDIT_W-1:0] o_credit;

  modport master (
    output i_money, i_cancel, i_refill,
    input  o_cola, o_change, o_busy, o_sold_out, o_credit
  );

  modport slave (
    input  i_money, i_cancel, i_refill,
    output o_cola, o_change, o_busy, o_sold_out, o_credit
  );
endinterface

// File: rtl/vm_change_dispenser.sv
// Loadable down-counter emitting one change pulse per cycle while enabled
// and non-zero.
module vm_change_dispenser #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         run_i,
  output logic         busy_o,
  output logic         last_o,
  output logic         pulse_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load overrides counting down.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (run_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o  = (cnt_q != {W{1'b0}});
  assign last_o  = (cnt_q == {{(W-1){1'b0}}, 1'b1});
  assign pulse_o = run_i && busy_o;

endmodule

// File: rtl/param_vending_machine.sv
// Top-level vending control FSM: credit, stock and state; change pulses come
// from vm_change_dispenser. Optional idle auto-refund under VM_AUTO_CANCEL_EN.
module param_vending_machine
  import vm_pkg::*;
#(
  parameter int PRICE       = 5,
  parameter int CREDIT_W    = 4,
  parameter int STOCK_INIT  = 8,
  parameter int STOCK_W     = 4,
  parameter int TIMEOUT_CYC = 50000000
) (
  input logic sys_clk,
  input logic sys_rst_n,
  vm_if.slave bus
);

  if ((PRICE < 1) || ((2 ** CREDIT_W) - 1 < PRICE + 1) || (STOCK_INIT > (2 ** STOCK_W) - 1)) begin : g_bad_params
    $error("param_vending_machine: PRICE/CREDIT_W/STOCK_INIT out of range");
  end

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic [1:0]          coin_s;
  logic [CREDIT_W-1:0] sum_s;
  logic                cancel_s;
  logic                timeout_s;
  logic                sold_out_s;
  logic                load_s;
  logic [CREDIT_W-1:0] load_val_s;
  logic                disp_busy_s;
  logic                disp_last_s;
  logic                disp_pulse_s;

  assign coin_s     = coin_units(bus.i_money);
  assign sum_s      = credit_q + CREDIT_W'(coin_s);
  assign sold_out_s = (stock_q == {STOCK_W{1'b0}});
  assign cancel_s   = bus.i_cancel || timeout_s;

`ifdef VM_AUTO_CANCEL_EN
  logic [31:0] idle_q, idle_d;

  assign timeout_s = (state_q == COLLECT) && (idle_q == 32'(TIMEOUT_CYC - 1));

  // Idle counter runs only while credit sits untouched in COLLECT.
  always_comb begin
    idle_d = idle_q;
    if ((state_q != COLLECT) || (coin_s != 2'd0) || (credit_q == {CREDIT_W{1'b0}}) || timeout_s) begin
      idle_d = 32'd0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, credit and change-load decisions; cancel beats sold-out beats vend.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    load_s     = 1'b0;
    load_val_s = {CREDIT_W{1'b0}};
    case (state_q)
      COLLECT: begin
        if (cancel_s && (sum_s != {CREDIT_W{1'b0}})) begin
          load_s     = 1'b1;
          load_val_s = sum_s;
          credit_d   = {CREDIT_W{1'b0}};
          state_d    = REFUND;
        end else if (sold_out_s && (coin_s != 2'd0)) begin
          load_s     = 1'b1;
          load_val_s = CREDIT_W'(coin_s);
          state_d    = REFUND;
        end else if (sum_s >= CREDIT_W'(PRICE)) begin
          load_s     = 1'b1;
          load_val_s = sum_s - CREDIT_W'(PRICE);
          credit_d   = {CREDIT_W{1'b0}};
          state_d    = VEND;
        end else begin
          credit_d   = sum_s;
        end
      end
      VEND: begin
        if (disp_busy_s) begin
          state_d = REFUND;
        end else begin
          state_d = COLLECT;
        end
      end
      REFUND: begin
        if (disp_last_s || !disp_busy_s) begin
          state_d = COLLECT;
        end else begin
          state_d = REFUND;
        end
      end
      default: begin
        state_d  = COLLECT;
        credit_d = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // Stock: refill wins over the vend decrement.
  always_comb begin
    stock_d = stock_q;
    if (bus.i_refill) begin
      stock_d = STOCK_W'(STOCK_INIT);
    end else if ((state_q == VEND) && !sold_out_s) begin
      stock_d = stock_q - {{(STOCK_W-1){1'b0}}, 1'b1};
    end else begin
      stock_d = stock_q;
    end
  end

  // FSM, credit and stock registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= COLLECT;
      credit_q <= {CREDIT_W{1'b0}};
      stock_q  <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
    end
  end

  vm_change_dispenser #(.W(CREDIT_W)) u_disp (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .load_i  (load_s),
    .value_i (load_val_s),
    .run_i   (state_q == REFUND),
    .busy_o  (disp_busy_s),
    .last_o  (disp_last_s),
    .pulse_o (disp_pulse_s)
  );

  assign bus.o_cola     = (state_q == VEND);
  assign bus.o_change   = disp_pulse_s;
  assign bus.o_busy     = (state_q != COLLECT);
  assign bus.o_sold_out = sold_out_s;
  assign bus.o_credit   = credit_q;

endmodule

// File: doc/param_vending_machine.md
Name: param_vending_machine

Overview:
Parametrised successor to the single-price cola vending FSM. Accepts 0.5-yuan and 1-yuan coins and vends one item once credit reaches a configurable price. Adds a stock counter with sold-out refund, a cancel/refund path, and serial change dispensing (one 0.5-yuan pulse per cycle). Sits in the Lab3 vending design as the top-level control FSM driven by the coin input and front-panel buttons.

Parameters:
PRICE, 5, item price in 0.5-yuan units (5 = 2.5 yuan); legal range 1..(2^CREDIT_W - 2)
CREDIT_W, 4, credit/change counter width; must satisfy 2^CREDIT_W - 1 >= PRICE + 1 (elaboration-time check)
STOCK_INIT, 8, stock loaded at reset and on refill
STOCK_W, 4, stock counter width; STOCK_INIT <= 2^STOCK_W - 1
TIMEOUT_CYC, 50000000, idle cycles before auto-refund (used only with the optional feature)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  synchronous active-low reset
i_money  in  2  coin this cycle: 0 none, 1 = 0.5 yuan, 2 = 1 yuan, 3 invalid (ignored)
i_cancel  in  1  refund request, level sampled each cycle
i_refill  in  1  reload stock to STOCK_INIT
o_cola  out  1  one-cycle vend pulse
o_change  out  1  one-cycle pulse per 0.5 yuan returned
o_busy  out  1  high in VEND/REFUND; coins ignored while high
o_sold_out  out  1  stock == 0
o_credit  out  CREDIT_W  current accumulated credit

Behaviour:
- All state is registered. On the sys_clk edge with sys_rst_n == 0: state = COLLECT, credit = 0, change_cnt = 0, stock = STOCK_INIT. o_cola, o_change and o_busy are 0, o_credit is 0, and o_sold_out is (STOCK_INIT == 0).
- A reset mid-operation discards any credit or pending change. No pulses are emitted.
- Outputs are Moore (decoded from registers). o_cola is high exactly while state == VEND. o_change is high exactly while state == REFUND.
- COLLECT:
  - coin = 0/1/2 units per i_money; code 3 adds 0.
  - sum = credit + coin.
  - Priority 1: i_cancel && sum > 0 -> change_cnt = sum, credit = 0, go to REFUND.
  - Priority 2: o_sold_out && coin > 0 -> change_cnt = coin, go to REFUND.
  - Priority 3: sum >= PRICE -> change_cnt = sum - PRICE, credit = 0, go to VEND.
  - Otherwise credit = sum.
  - i_cancel with sum == 0 is a no-op.
- VEND: held for exactly 1 cycle; stock decrements by 1. Next state is REFUND if change_cnt > 0, else COLLECT.
- REFUND: change_cnt decrements each cycle; go to COLLECT on the cycle change_cnt reaches 0. This gives exactly N consecutive o_change pulses for N units.
- Latency: a coin sampled at edge n that completes the price gives o_cola high during cycle n+1. The change pulses follow at cycles n+2 onward.
- While busy: i_money and i_cancel are ignored and the coins are lost. Coin handling during busy is the mechanism's responsibility.
- i_refill is honoured in any state and sets stock = STOCK_INIT. If it coincides with the VEND decrement, refill wins.
- Stock never decrements below 0; VEND is unreachable when stock == 0.

Optional Feature:
- Macro VM_AUTO_CANCEL_EN.
- Defined: an idle counter is added. It is cleared on any coin, on leaving COLLECT, or when credit == 0, and increments in COLLECT while credit > 0. On reaching TIMEOUT_CYC - 1 it behaves exactly as i_cancel: full credit refunded via REFUND.
- Undefined: no counter, no timeout; credit is held indefinitely.

Decomposition:
- Package vm_pkg holds:
  - state localparams COLLECT / VEND / REFUND (2-bit encoding)
  - coin code constants COIN_NONE / COIN_HALF / COIN_ONE / COIN_BAD
  - a coin-to-units function
- One natural sub-module, vm_change_dispenser: loadable down-counter (load, value, busy, pulse) producing the o_change pulse train. The top-level FSM handles only credit, stock and state.

Test Plan:
1. PRICE=5; i_money 2,2,2 on consecutive cycles -> o_credit 2, 4; o_cola pulse on the cycle after the third coin; then exactly 1 o_change pulse; o_credit = 0, stock 8 -> 7.
2. i_money 1 x5 -> one o_cola pulse, zero o_change pulses, back to COLLECT.
3. i_money 2, 1, then i_cancel=1 -> 3 consecutive o_change pulses, no o_cola, o_credit = 0.
4. STOCK_INIT=2; two vends -> o_sold_out = 1; then coin 2 -> 2 change pulses, no cola; i_refill -> o_sold_out = 0, stock = 2.
5. i_money 3 and coins during o_busy -> credit unchanged. sys_rst_n low for one edge mid-REFUND -> all outputs 0 next cycle, stock = STOCK_INIT.
6. VM_AUTO_CANCEL_EN defined, TIMEOUT_CYC=10; coin 1 then idle -> 1 o_change pulse after 10 idle cycles. With the macro undefined, credit stays 1.
